// File: rtl/retrosoc_rst_pkg.sv
// Shared definitions for the retrosoc reset controller.
// Holds the sequencer state encoding and the bit positions of the
// sticky reset-cause register, plus a small width helper.
package retrosoc_rst_pkg;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_PERIPH = 2'd1,
        S_RUN    = 2'd2
    } rst_state_e;

    localparam int unsigned CAUSE_POR    = 0;
    localparam int unsigned CAUSE_BTN    = 1;
    localparam int unsigned CAUSE_HK     = 2;
    localparam int unsigned CAUSE_CLKSEL = 3;
    localparam int unsigned CAUSE_TRAP   = 4;
    localparam int unsigned CAUSE_W      = 5;

    // Counter width able to hold values 0..max(a, b).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/retrosoc_sync.sv
// N-stage flop synchronizer for a single asynchronous level.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, loads RST_VAL into every stage
//   d    - asynchronous input
//   q    - synchronized output (last stage)
module retrosoc_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift chain; stage 0 is the only flop that sees the raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/retrosoc_rst_ctrl.sv
// Reset sequencer for the retrosoc core.
// Merges the pad button, housekeeping-SPI request, clock-select changes and
// an optional core trap into two sequenced active-low resets: peripherals
// are released STRETCH_CYC cycles after the last request clears, the CPU
// core PERIPH_LEAD cycles after that. Sticky cause bits are kept for firmware.
// Ports:
//   clk_i           - system clock (post clock-select)
//   rst_i           - synchronous active-high power-on reset
//   btn_rst_n_i     - pad reset button, active low, asynchronous
//   hk_rst_i        - housekeeping reset request level, asynchronous
//   clk_sel_i       - PLL bypass select, asynchronous
//   trap_i          - core trap, clk_i domain
//   trap_rst_en_i   - enables trap-triggered reset
//   rst_cause_clr_i - single-cycle clear of the cause register
//   core_rst_n_o    - CPU reset, active low
//   periph_rst_n_o  - peripheral/bus reset, active low
//   rst_cause_o     - sticky cause [0]POR [1]button [2]hk [3]clksel [4]trap
//   busy_o          - high whenever the sequencer is not in S_RUN
module retrosoc_rst_ctrl
    import retrosoc_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 255,
    parameter int unsigned STRETCH_CYC  = 64,
    parameter int unsigned PERIPH_LEAD  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               btn_rst_n_i,
    input  logic               hk_rst_i,
    input  logic               clk_sel_i,
    input  logic               trap_i,
    input  logic               trap_rst_en_i,
    input  logic               rst_cause_clr_i,
    output logic               core_rst_n_o,
    output logic               periph_rst_n_o,
    output logic [CAUSE_W-1:0] rst_cause_o,
    output logic               busy_o
);

    localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYC, 1);
    localparam int unsigned CNT_W = cnt_width(STRETCH_CYC, PERIPH_LEAD);

    localparam logic [DEB_W-1:0] DEB_MAX      = DEB_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST    = CNT_W'(PERIPH_LEAD - 1);

    rst_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [DEB_W-1:0]   deb_cnt;

    logic               btn_sync;
    logic               hk_sync;
    logic               clk_sel_sync;
    logic               clk_sel_prev;
    logic               trap_prev;

    logic               in_hold;
    logic               btn_req;
    logic               hk_req;
    logic               clksel_pulse;
    logic               trap_pulse;
    logic               req_any;
    logic [CAUSE_W-1:0] cause_set;

    // Idle button is high, so its chain resets to 1 to avoid a false press.
    retrosoc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_btn (
        .clk (clk_i),
        .rst (rst_i),
        .d   (btn_rst_n_i),
        .q   (btn_sync)
    );

    retrosoc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_hk (
        .clk (clk_i),
        .rst (rst_i),
        .d   (hk_rst_i),
        .q   (hk_sync)
    );

    retrosoc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk_sel (
        .clk (clk_i),
        .rst (rst_i),
        .d   (clk_sel_i),
        .q   (clk_sel_sync)
    );

    // Button debounce: count consecutive low samples, saturating.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_cnt <= '0;
        end else if (btn_sync) begin
            deb_cnt <= '0;
        end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Edge-detect history; updated every cycle, including during S_HOLD.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sel_prev <= 1'b0;
            trap_prev    <= 1'b0;
        end else begin
            clk_sel_prev <= clk_sel_sync;
            trap_prev    <= trap_i;
        end
    end

    // Request decode; pulse sources are masked while resets are already held.
    always_comb begin
        in_hold      = (state == S_HOLD);
        btn_req      = (deb_cnt == DEB_MAX);
        hk_req       = hk_sync;
        clksel_pulse = (clk_sel_sync ^ clk_sel_prev) & ~in_hold;
        trap_pulse   = trap_i & ~trap_prev & trap_rst_en_i & ~in_hold;
        req_any      = btn_req | hk_req | clksel_pulse | trap_pulse;

        cause_set               = '0;
        cause_set[CAUSE_BTN]    = btn_req;
        cause_set[CAUSE_HK]     = hk_req;
        cause_set[CAUSE_CLKSEL] = clksel_pulse;
        cause_set[CAUSE_TRAP]   = trap_pulse;
    end

    // Sticky cause register; a clear keeps only bits being set this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_cause_o            <= '0;
            rst_cause_o[CAUSE_POR] <= 1'b1;
        end else if (rst_cause_clr_i) begin
            rst_cause_o <= cause_set;
        end else begin
            rst_cause_o <= rst_cause_o | cause_set;
        end
    end

    // Sequencer with the reset outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_HOLD;
            cnt            <= '0;
            core_rst_n_o   <= 1'b0;
            periph_rst_n_o <= 1'b0;
            busy_o         <= 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    if (req_any) begin
                        cnt <= '0;
                    end else if (cnt == STRETCH_LAST) begin
                        state          <= S_PERIPH;
                        cnt            <= '0;
                        periph_rst_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PERIPH: begin
                    if (req_any) begin
                        state          <= S_HOLD;
                        cnt            <= '0;
                        core_rst_n_o   <= 1'b0;
                        periph_rst_n_o <= 1'b0;
                        busy_o         <= 1'b1;
                    end else if (cnt == LEAD_LAST) begin
                        state        <= S_RUN;
                        cnt          <= '0;
                        core_rst_n_o <= 1'b1;
                        busy_o       <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (req_any) begin
                        state          <= S_HOLD;
                        cnt            <= '0;
                        core_rst_n_o   <= 1'b0;
                        periph_rst_n_o <= 1'b0;
                        busy_o         <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_HOLD;
                    cnt            <= '0;
                    core_rst_n_o   <= 1'b0;
                    periph_rst_n_o <= 1'b0;
                    busy_o         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retrosoc_rst_ctrl.sv
// Scoreboard bench for retrosoc_rst_ctrl (SYNC=2, DEBOUNCE=4, STRETCH=8, LEAD=4).
// Stimulus pushes the expected output word and the clock edge it must appear
// on; the monitor pops an entry every time the output word changes.
module tb_retrosoc_rst_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] val;   // {core, periph, busy, cause[4:0]}
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       btn_rst_n_i;
    logic       hk_rst_i;
    logic       clk_sel_i;
    logic       trap_i;
    logic       trap_rst_en_i;
    logic       rst_cause_clr_i;
    logic       core_rst_n_o;
    logic       periph_rst_n_o;
    logic [4:0] rst_cause_o;
    logic       busy_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    exp_t exp_q[$];

    retrosoc_rst_ctrl #(
        .SYNC_STAGES  (2),
        .DEBOUNCE_CYC (4),
        .STRETCH_CYC  (8),
        .PERIPH_LEAD  (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .btn_rst_n_i     (btn_rst_n_i),
        .hk_rst_i        (hk_rst_i),
        .clk_sel_i       (clk_sel_i),
        .trap_i          (trap_i),
        .trap_rst_en_i   (trap_rst_en_i),
        .rst_cause_clr_i (rst_cause_clr_i),
        .core_rst_n_o    (core_rst_n_o),
        .periph_rst_n_o  (periph_rst_n_o),
        .rst_cause_o     (rst_cause_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input int c, input logic core, input logic periph,
                             input logic busy, input logic [4:0] cause, input string tag);
        exp_t e;
        e.cyc = c;
        e.val = {core, periph, busy, cause};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Advance to just after clock edge number c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the output word is matched against the queue.
    logic [7:0] prev = 8'bx;
    always @(negedge clk) begin
        logic [7:0] cur;
        exp_t       e;
        cur = {core_rst_n_o, periph_rst_n_o, busy_o, rst_cause_o};
        if (cur !== prev) begin
            prev = cur;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    errors++;
                    $display("FAIL %s got cyc=%0d val=%b required cyc=%0d val=%b",
                             e.tag, cyc, cur, e.cyc, e.val);
                end
            end
        end
        if (done) begin
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s never_seen required cyc=%0d val=%b", e.tag, e.cyc, e.val);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int p;
        rst_i           = 1'b1;
        btn_rst_n_i     = 1'b1;
        hk_rst_i        = 1'b0;
        clk_sel_i       = 1'b0;
        trap_i          = 1'b0;
        trap_rst_en_i   = 1'b0;
        rst_cause_clr_i = 1'b0;

        // POR: reset values, then periph 8 and core 12 edges after the last reset edge.
        expect_ev(1, 1'b0, 1'b0, 1'b1, 5'b00001, "por_reset_state");
        goto(3);
        rst_i = 1'b0;
        expect_ev(11, 1'b0, 1'b1, 1'b1, 5'b00001, "por_periph_release");
        expect_ev(15, 1'b1, 1'b1, 1'b0, 5'b00001, "por_core_release");
        goto(22);

        // hk level held 20 cycles: assert after sync, release 8/4 after synced drop.
        t = cyc;
        hk_rst_i = 1'b1;
        expect_ev(t + 3, 1'b0, 1'b0, 1'b1, 5'b00101, "hk_assert");
        goto(t + 20);
        hk_rst_i = 1'b0;
        expect_ev(t + 30, 1'b0, 1'b1, 1'b1, 5'b00101, "hk_periph_release");
        expect_ev(t + 34, 1'b1, 1'b1, 1'b0, 5'b00101, "hk_core_release");
        goto(t + 40);

        // Button glitch of 3 cycles: debounce never saturates, no output change.
        t = cyc;
        btn_rst_n_i = 1'b0;
        goto(t + 3);
        btn_rst_n_i = 1'b1;
        goto(t + 12);

        // Button held 10 cycles: reset 7 edges after press.
        t = cyc;
        btn_rst_n_i = 1'b0;
        expect_ev(t + 7, 1'b0, 1'b0, 1'b1, 5'b00111, "btn_assert");
        goto(t + 10);
        btn_rst_n_i = 1'b1;
        expect_ev(t + 21, 1'b0, 1'b1, 1'b1, 5'b00111, "btn_periph_release");
        expect_ev(t + 25, 1'b1, 1'b1, 1'b0, 5'b00111, "btn_core_release");
        goto(t + 30);

        // clk_sel toggle in RUN, second toggle during HOLD must not extend it.
        t = cyc;
        clk_sel_i = 1'b1;
        expect_ev(t + 3, 1'b0, 1'b0, 1'b1, 5'b01111, "clksel_assert");
        goto(t + 5);
        clk_sel_i = 1'b0;
        expect_ev(t + 11, 1'b0, 1'b1, 1'b1, 5'b01111, "clksel_periph_release");
        expect_ev(t + 15, 1'b1, 1'b1, 1'b0, 5'b01111, "clksel_core_release");
        goto(t + 20);

        // Trap with enable low: ignored.
        t = cyc;
        trap_i = 1'b1;
        goto(t + 1);
        trap_i = 1'b0;
        goto(t + 6);

        // Trap with enable high: reset on the next edge.
        trap_rst_en_i = 1'b1;
        t = cyc;
        trap_i = 1'b1;
        expect_ev(t + 1, 1'b0, 1'b0, 1'b1, 5'b11111, "trap_assert");
        goto(t + 2);
        trap_i = 1'b0;
        expect_ev(t + 9, 1'b0, 1'b1, 1'b1, 5'b11111, "trap_periph_release");
        expect_ev(t + 13, 1'b1, 1'b1, 1'b0, 5'b11111, "trap_core_release");
        goto(t + 18);
        trap_rst_en_i = 1'b0;

        // Clear on the same edge the button request is first seen: only bit1 survives.
        t = cyc;
        btn_rst_n_i = 1'b0;
        expect_ev(t + 7, 1'b0, 1'b0, 1'b1, 5'b00010, "clr_with_btn");
        goto(t + 6);
        rst_cause_clr_i = 1'b1;
        goto(t + 7);
        rst_cause_clr_i = 1'b0;
        goto(t + 10);
        btn_rst_n_i = 1'b1;
        p = t + 21;
        expect_ev(p, 1'b0, 1'b1, 1'b1, 5'b00010, "clr_periph_release");

        // hk pulse while in S_PERIPH: back to HOLD before core releases, full restart.
        goto(p + 1);
        hk_rst_i = 1'b1;
        expect_ev(p + 4, 1'b0, 1'b0, 1'b1, 5'b00110, "periph_hk_reassert");
        goto(p + 4);
        hk_rst_i = 1'b0;
        expect_ev(p + 14, 1'b0, 1'b1, 1'b1, 5'b00110, "periph_hk_periph_release");
        expect_ev(p + 18, 1'b1, 1'b1, 1'b0, 5'b00110, "periph_hk_core_release");
        goto(p + 25);

        done = 1'b1;
    end

endmodule
